// File: rtl/pixel_write_fifo.sv
// Buffers 2-pixel colour/Z write requests and drains them as Avalon-MM writes (colour, then optional Z).
// Enqueue-to-mem_write is 2 edges; outputs hold while mem_waitrequest is high, one accepted write per cycle.
module pixel_write_fifo #(
  parameter int FIFO_DEPTH      = 32,
  parameter int FIFO_DEPTH_LOG2 = 5
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       z_active,
  input  logic                       enqueue,
  input  logic [28:0]                color_address,
  input  logic [63:0]                color,
  input  logic [28:0]                z_address,
  input  logic [63:0]                z,
  input  logic [1:0]                 pixel_active,
  output logic [FIFO_DEPTH_LOG2-1:0] size,
  output logic                       full,
  output logic                       busy,
  output logic                       overflow,
  output logic [28:0]                mem_address,
  output logic [63:0]                mem_writedata,
  output logic [7:0]                 mem_byteenable,
  output logic                       mem_write,
  input  logic                       mem_waitrequest
);

  typedef struct packed {
    logic [28:0] color_address;
    logic [63:0] color;
    logic [28:0] z_address;
    logic [63:0] z;
    logic [1:0]  pixel_active;
  } entry_t;

  typedef enum logic [1:0] {IDLE, COLOR, ZWRITE} state_t;

  localparam logic [FIFO_DEPTH_LOG2:0]   CNT_ONE = {{FIFO_DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE = {{(FIFO_DEPTH_LOG2-1){1'b0}}, 1'b1};

  entry_t                     fifo_mem [FIFO_DEPTH];
  entry_t                     entry_in;
  entry_t                     head;
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   count;
  logic                       head_ready;
  logic                       not_empty;
  logic                       head_live;
  logic                       push;
  logic                       pop;
  logic                       accepted;
  logic                       load_color;
  logic                       load_z;
  logic                       stop;
  logic [28:0]                z_address_q;
  logic [63:0]                z_q;
  logic                       z_active_q;
  state_t                     state;
  state_t                     state_nxt;

  assign entry_in  = '{color_address, color, z_address, z, pixel_active};
  assign head      = fifo_mem[rd_ptr];
  assign not_empty = (count != '0);
  assign head_live = not_empty && (head.pixel_active != 2'b00);
  // Power-of-two depth: the count MSB alone marks the full case.
  assign full      = count[FIFO_DEPTH_LOG2];
  assign size      = count[FIFO_DEPTH_LOG2-1:0];
  assign push      = enqueue && !full;
  assign accepted  = mem_write && !mem_waitrequest;
  assign busy      = not_empty || (state != IDLE);

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= entry_in;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      head_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (enqueue && full) overflow <= 1'b1;
      // An entry becomes eligible for an idle pop one cycle after it lands.
      head_ready <= not_empty;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (not_empty && head_ready && head.pixel_active != 2'b00) state_nxt = COLOR;
      COLOR:  if (accepted) state_nxt = z_active_q ? ZWRITE : (head_live ? COLOR : IDLE);
      ZWRITE: if (accepted) state_nxt = head_live ? COLOR : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A zero-mask head is left for IDLE to discard, so the back-to-back path never pops it.
  always_comb begin
    pop        = 1'b0;
    load_color = 1'b0;
    load_z     = 1'b0;
    stop       = 1'b0;
    case (state)
      IDLE: begin
        if (not_empty && head_ready) begin
          pop        = 1'b1;
          load_color = (head.pixel_active != 2'b00);
        end
      end
      COLOR: begin
        if (accepted) begin
          if (z_active_q) begin
            load_z = 1'b1;
          end else if (head_live) begin
            pop        = 1'b1;
            load_color = 1'b1;
          end else begin
            stop = 1'b1;
          end
        end
      end
      ZWRITE: begin
        if (accepted) begin
          if (head_live) begin
            pop        = 1'b1;
            load_color = 1'b1;
          end else begin
            stop = 1'b1;
          end
        end
      end
      default: stop = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_writedata  <= '0;
      mem_byteenable <= '0;
      z_address_q    <= '0;
      z_q            <= '0;
      z_active_q     <= 1'b0;
    end else if (load_color) begin
      mem_write      <= 1'b1;
      mem_address    <= head.color_address;
      mem_writedata  <= head.color;
      mem_byteenable <= {{4{head.pixel_active[1]}}, {4{head.pixel_active[0]}}};
      z_address_q    <= head.z_address;
      z_q            <= head.z;
      z_active_q     <= z_active;
    end else if (load_z) begin
      mem_address    <= z_address_q;
      mem_writedata  <= z_q;
    end else if (stop) begin
      mem_write      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_write_fifo.sv
// Directed bench for pixel_write_fifo: expected writes queued at enqueue, checked by an accept monitor.
module tb_pixel_write_fifo;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        z_active;
  logic        enqueue;
  logic [28:0] color_address;
  logic [63:0] color;
  logic [28:0] z_address;
  logic [63:0] z;
  logic [1:0]  pixel_active;
  logic [4:0]  size;
  logic        full;
  logic        busy;
  logic        overflow;
  logic [28:0] mem_address;
  logic [63:0] mem_writedata;
  logic [7:0]  mem_byteenable;
  logic        mem_write;
  logic        mem_waitrequest;

  typedef struct packed {
    logic [28:0] a;
    logic [63:0] d;
    logic [7:0]  be;
  } wr_t;

  wr_t exp_q[$];
  int  checks  = 0;
  int  errors  = 0;
  int  wr_cnt  = 0;
  int  run     = 0;
  int  max_run = 0;
  int  snap;

  pixel_write_fifo dut (
    .clock(clock), .reset_n(reset_n), .z_active(z_active), .enqueue(enqueue),
    .color_address(color_address), .color(color), .z_address(z_address), .z(z),
    .pixel_active(pixel_active), .size(size), .full(full), .busy(busy), .overflow(overflow),
    .mem_address(mem_address), .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_write(mem_write), .mem_waitrequest(mem_waitrequest)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted write must match the oldest expected write.
  always @(negedge clock) begin
    if (reset_n) begin
      if (mem_write && !mem_waitrequest) begin
        wr_cnt++;
        run++;
        if (run > max_run) max_run = run;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h with no write expected", mem_address);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("write", {mem_address, mem_writedata, mem_byteenable}, {e.a, e.d, e.be});
        end
      end else begin
        run = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic enq(input logic [28:0] ca, input logic [63:0] c, input logic [28:0] za,
                     input logic [63:0] zd, input logic [1:0] pa, input logic [7:0] exp_be,
                     input bit expect_it);
    enqueue       = 1'b1;
    color_address = ca;
    color         = c;
    z_address     = za;
    z             = zd;
    pixel_active  = pa;
    if (expect_it && exp_be != 8'h00) begin
      exp_q.push_back('{ca, c, exp_be});
      if (z_active) exp_q.push_back('{za, zd, exp_be});
    end
    tick();
    enqueue = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done = 0;
    for (int i = 0; i < budget; i++) begin
      if (!busy && exp_q.size() == 0) begin
        done = 1;
        break;
      end
      tick();
    end
    check(name, {127'd0, done}, 128'd1);
  endtask

  initial begin
    reset_n = 1'b0; z_active = 1'b0; enqueue = 1'b0; mem_waitrequest = 1'b0;
    color_address = '0; color = '0; z_address = '0; z = '0; pixel_active = 2'b00;
    tick(); tick();
    check("reset_status", {size, full, busy, overflow}, {5'd0, 3'b000});
    check("reset_mem", {mem_write, mem_address, mem_writedata, mem_byteenable}, 128'd0);
    reset_n = 1'b1;
    tick();

    // Single entry, colour then Z, with latency and pulse-length checks.
    z_active = 1'b1;
    enq(29'h100, 64'h11112222_33334444, 29'h200, 64'h0000AAAA_0000BBBB, 2'b11, 8'hFF, 1);
    check("lat_edge_n", {127'd0, mem_write}, 128'd0);
    tick();
    check("lat_edge_n1", {127'd0, mem_write}, 128'd0);
    tick();
    check("lat_edge_n2", {mem_write, mem_address, mem_byteenable}, {1'b1, 29'h100, 8'hFF});
    tick();
    check("z_follows", {mem_write, mem_address, mem_byteenable}, {1'b1, 29'h200, 8'hFF});
    tick();
    check("two_cycle_pulse", {127'd0, mem_write}, 128'd0);
    check("busy_after", {127'd0, busy}, 128'd0);
    wait_idle("idle_t1", 20);

    // Byte-enable patterns, including a fully masked entry.
    z_active = 1'b0;
    snap = wr_cnt;
    enq(29'h300, 64'hAAAAAAAA_55555555, 29'h0, 64'h0, 2'b01, 8'h0F, 1);
    enq(29'h301, 64'h12345678_9ABCDEF0, 29'h0, 64'h0, 2'b10, 8'hF0, 1);
    enq(29'h302, 64'hFFFFFFFF_FFFFFFFF, 29'h0, 64'h0, 2'b00, 8'h00, 1);
    wait_idle("idle_t2", 30);
    check("be_write_count", wr_cnt - snap, 2);
    check("size_after_discard", {123'd0, size}, 128'd0);

    // Waitrequest stall during the colour write.
    z_active = 1'b1;
    mem_waitrequest = 1'b1;
    enq(29'h400, 64'hCAFEF00D_DEADBEEF, 29'h500, 64'h01234567_89ABCDEF, 2'b11, 8'hFF, 1);
    for (int i = 0; i < 10 && !mem_write; i++) tick();
    check("stall_write_seen", {127'd0, mem_write}, 128'd1);
    for (int i = 0; i < 5; i++) begin
      check("stall_stable", {mem_write, mem_address, mem_writedata, mem_byteenable},
            {1'b1, 29'h400, 64'hCAFEF00D_DEADBEEF, 8'hFF});
      if (i < 4) tick();
    end
    mem_waitrequest = 1'b0;
    tick();
    check("z_after_release", {mem_write, mem_address}, {1'b1, 29'h500});
    wait_idle("idle_t3", 20);

    // Fill to full behind a stalled write, overflow, then drain across pointer wrap.
    z_active = 1'b0;
    mem_waitrequest = 1'b1;
    snap = wr_cnt;
    enq(29'h0FFF, 64'hB10C_0000, 29'h0, 64'h0, 2'b11, 8'hFF, 1);
    tick(); tick(); tick();
    check("blocker_presented", {127'd0, mem_write}, 128'd1);
    for (int i = 0; i < 32; i++) enq(29'h1000 + 29'(i), 64'hDEAD_0000_0000 + 64'(i), 29'h0, 64'h0, 2'b11, 8'hFF, 1);
    check("full_at_32", {full, size, overflow}, {1'b1, 5'd0, 1'b0});
    enq(29'h1FFF, 64'hBAD, 29'h0, 64'h0, 2'b11, 8'hFF, 0);
    check("overflow_at_33", {full, overflow}, {1'b1, 1'b1});
    mem_waitrequest = 1'b0;
    wait_idle("idle_t4", 200);
    check("drain_count", wr_cnt - snap, 33);
    check("overflow_sticky", {127'd0, overflow}, 128'd1);

    // Back-to-back burst without bubbles.
    snap = wr_cnt;
    max_run = 0;
    for (int i = 0; i < 4; i++) enq(29'h2000 + 29'(i), 64'h5000 + 64'(i), 29'h0, 64'h0, 2'b11, 8'hFF, 1);
    wait_idle("idle_t5", 30);
    check("burst_count", wr_cnt - snap, 4);
    check("burst_no_bubble", max_run, 4);

    // Reset mid-burst, then recovery latency.
    z_active = 1'b1;
    for (int i = 0; i < 3; i++) enq(29'h3000 + 29'(i), 64'h7000 + 64'(i), 29'h3800 + 29'(i), 64'h7800 + 64'(i), 2'b11, 8'hFF, 1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_outputs", {mem_write, size, busy, overflow, full}, {1'b0, 5'd0, 3'b000});
    exp_q.delete();
    tick(); tick();
    reset_n = 1'b1;
    tick();
    snap = wr_cnt;
    enq(29'h4000, 64'h4444_5555, 29'h4100, 64'h6666_7777, 2'b11, 8'hFF, 1);
    tick();
    check("post_rst_lat_n1", {127'd0, mem_write}, 128'd0);
    tick();
    check("post_rst_lat_n2", {mem_write, mem_address}, {1'b1, 29'h4000});
    wait_idle("idle_t6", 20);
    check("post_rst_count", wr_cnt - snap, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
